// File: rtl/parity_engine_pkg.sv
// Shared encodings for the UART parity engine: parity modes, FSM states and
// the mode-to-parity-bit mapping.
package parity_engine_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ACCUM   = 2'b01;
    localparam logic [1:0] ST_PAR_RDY = 2'b10;

    function automatic logic par_of(input logic acc, input logic [1:0] mode);
        case (mode)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/parity_engine_par_err_cnt.sv
// Saturating error counter; a clear coinciding with an increment yields 1 so
// the error that arrives with the clear is not lost.
module par_err_cnt #(
    parameter int Cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [Cnt_width-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= Cnt_width'(inc);
        else if (inc && cnt != '1)
            cnt <= cnt + Cnt_width'(1);
    end

endmodule

// File: rtl/parity_engine.sv
// Serial parity generator/checker for the UART TX/RX paths: one data bit per
// BIT_VLD strobe, run-time frame length and parity mode, sticky error status.
module parity_engine
    import parity_engine_pkg::*;
#(
    parameter  int Data_width = 8,
    parameter  int Cnt_width  = 8,
    localparam int Len_width  = $clog2(Data_width + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [Len_width-1:0] FRM_LEN,
    input  logic [1:0]           PAR_MODE,
    input  logic                 CHK_EN,
    input  logic                 BIT_VLD,
    input  logic                 BIT_IN,
    input  logic                 PAR_SMP,
    input  logic                 CLR_STS,
    output logic                 PAR_BIT,
    output logic                 PAR_VLD,
    output logic                 BUSY,
    output logic                 PAR_ERR,
    output logic                 ERR_STS,
    output logic                 SEQ_ERR,
    output logic [Cnt_width-1:0] ERR_CNT
);

    logic [1:0]           state, state_nxt;
    logic                 acc, acc_nxt;
    logic [Len_width-1:0] cnt, cnt_nxt;
    logic [Len_width-1:0] len, len_nxt, len_clamped;
    logic [1:0]           mode, mode_nxt;
    logic                 par_bit_q, par_err_q, err_sts_q, seq_err_q;
    logic                 perr_hit, seq_hit;

    // Zero or oversized lengths fall back to a full-width frame.
    always_comb begin
        len_clamped = FRM_LEN;
        if (FRM_LEN == '0 || 32'(FRM_LEN) > Data_width)
            len_clamped = Len_width'(Data_width);
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        len_nxt   = len;
        mode_nxt  = mode;
        perr_hit  = 1'b0;
        seq_hit   = 1'b0;
        if (START) begin
            // Abort/restart silently; same-cycle strobes are discarded.
            state_nxt = ST_ACCUM;
            acc_nxt   = 1'b0;
            cnt_nxt   = '0;
            len_nxt   = len_clamped;
            mode_nxt  = PAR_MODE;
        end else begin
            if (BIT_VLD) begin
                if (state == ST_ACCUM) begin
                    acc_nxt = acc ^ BIT_IN;
                    cnt_nxt = cnt + Len_width'(1);
                    if (cnt_nxt == len)
                        state_nxt = ST_PAR_RDY;
                end else begin
                    seq_hit = 1'b1;
                end
            end
            if (PAR_SMP) begin
                if (state == ST_PAR_RDY) begin
                    state_nxt = ST_IDLE;
                    perr_hit  = CHK_EN && (BIT_IN != par_bit_q);
                end else begin
                    seq_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            acc       <= 1'b0;
            cnt       <= '0;
            len       <= '0;
            mode      <= '0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            err_sts_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            len       <= len_nxt;
            mode      <= mode_nxt;
            par_bit_q <= par_of(acc_nxt, mode_nxt);
            par_err_q <= perr_hit;
            err_sts_q <= perr_hit | (err_sts_q & ~CLR_STS);
            seq_err_q <= seq_hit | (seq_err_q & ~CLR_STS);
        end
    end

    par_err_cnt #(.Cnt_width(Cnt_width)) u_err_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (CLR_STS),
        .inc   (perr_hit),
        .cnt   (ERR_CNT)
    );

    assign PAR_BIT = par_bit_q;
    assign PAR_VLD = (state == ST_PAR_RDY);
    assign BUSY    = (state != ST_IDLE);
    assign PAR_ERR = par_err_q;
    assign ERR_STS = err_sts_q;
    assign SEQ_ERR = seq_err_q;

endmodule

// File: tb/tb_parity_engine.sv
// Bench for parity_engine: directed frames with literal expectations plus a
// randomized run checked every cycle against a bit-queue reference model.
module tb_parity_engine;

    localparam int DW = 8;
    localparam int CW = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0, CHK_EN = 1'b0, BIT_VLD = 1'b0, BIT_IN = 1'b0;
    logic       PAR_SMP = 1'b0, CLR_STS = 1'b0;
    logic [3:0] FRM_LEN = '0;
    logic [1:0] PAR_MODE = '0;
    logic       PAR_BIT, PAR_VLD, BUSY, PAR_ERR, ERR_STS, SEQ_ERR;
    logic [CW-1:0] ERR_CNT;

    int nvec = 0;
    int nmis = 0;

    parity_engine #(.Data_width(DW), .Cnt_width(CW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .FRM_LEN(FRM_LEN), .PAR_MODE(PAR_MODE),
        .CHK_EN(CHK_EN), .BIT_VLD(BIT_VLD), .BIT_IN(BIT_IN), .PAR_SMP(PAR_SMP),
        .CLR_STS(CLR_STS), .PAR_BIT(PAR_BIT), .PAR_VLD(PAR_VLD), .BUSY(BUSY),
        .PAR_ERR(PAR_ERR), .ERR_STS(ERR_STS), .SEQ_ERR(SEQ_ERR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting bits, 2 parity ready.
    int   m_ph = 0, m_ph0, m_len = DW, m_cnt = 0;
    bit   m_bits[$];
    logic [1:0] m_mode = '0;
    bit   m_sts = 0, m_seq = 0, m_perr = 0, m_err, m_s;

    function automatic bit model_par();
        int ones = 0;
        foreach (m_bits[i]) ones += m_bits[i];
        case (m_mode)
            2'b00:   return bit'(ones % 2);
            2'b01:   return bit'(1 - ones % 2);
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_ph = 0; m_bits.delete(); m_sts = 0; m_seq = 0; m_perr = 0; m_cnt = 0;
        end else begin
            m_err = 0; m_s = 0; m_ph0 = m_ph;
            if (START) begin
                m_ph = 1; m_bits.delete(); m_mode = PAR_MODE;
                m_len = (FRM_LEN == 0 || FRM_LEN > DW) ? DW : int'(FRM_LEN);
            end else begin
                if (BIT_VLD) begin
                    if (m_ph0 == 1) begin
                        m_bits.push_back(BIT_IN);
                        if (m_bits.size() == m_len) m_ph = 2;
                    end else m_s = 1;
                end
                if (PAR_SMP) begin
                    if (m_ph0 == 2) begin
                        m_ph = 0;
                        m_err = CHK_EN && (BIT_IN != model_par());
                    end else m_s = 1;
                end
            end
            m_perr = m_err;
            m_sts  = m_err | (m_sts & !CLR_STS);
            m_seq  = m_s | (m_seq & !CLR_STS);
            if (CLR_STS) m_cnt = m_err;
            else if (m_err && m_cnt < (1 << CW) - 1) m_cnt++;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            chk("par_vld", PAR_VLD, m_ph == 2);
            chk("busy", BUSY, m_ph != 0);
            chk("par_err", PAR_ERR, m_perr);
            chk("err_sts", ERR_STS, m_sts);
            chk("seq_err", SEQ_ERR, m_seq);
            chk("err_cnt", 32'(ERR_CNT), m_cnt);
            if (m_ph == 2) chk("par_bit", PAR_BIT, model_par());
        end
    end

    task automatic start(input logic [3:0] l, input logic [1:0] m);
        START = 1; FRM_LEN = l; PAR_MODE = m;
        @(negedge CLK);
        START = 0;
    endtask

    task automatic send(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            BIT_VLD = 1; BIT_IN = d[i];
            @(negedge CLK);
        end
        BIT_VLD = 0; BIT_IN = 0;
    endtask

    task automatic smp(input logic c, input logic b, input logic clr);
        PAR_SMP = 1; CHK_EN = c; BIT_IN = b; CLR_STS = clr;
        @(negedge CLK);
        PAR_SMP = 0; CHK_EN = 0; BIT_IN = 0; CLR_STS = 0;
    endtask

    task automatic clear();
        CLR_STS = 1;
        @(negedge CLK);
        CLR_STS = 0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_outs", {PAR_BIT, PAR_VLD, PAR_ERR, ERR_STS, SEQ_ERR, ERR_CNT}, 0);
        RST = 1;
        @(negedge CLK);

        // Even/odd over 8'b1011_0010 (four ones).
        start(8, 2'b00); send(8'hB2, 8);
        chk("t1_vld", PAR_VLD, 1); chk("t1_even", PAR_BIT, 0);
        smp(0, 0, 0);
        start(8, 2'b01); send(8'hB2, 8);
        chk("t1_odd", PAR_BIT, 1);
        smp(0, 0, 0);

        // Short frame, then a surplus strobe.
        start(5, 2'b01); send(8'h07, 5);
        chk("t2_vld", PAR_VLD, 1); chk("t2_bit", PAR_BIT, 0);
        send(8'h01, 1);
        chk("t2_seq", SEQ_ERR, 1); chk("t2_still_rdy", PAR_VLD, 1);
        smp(0, 0, 0);

        // Receive check: wrong then right parity bit.
        start(8, 2'b00); send(8'h01, 8); smp(1, 0, 0);
        chk("t3_perr", PAR_ERR, 1); chk("t3_sts", ERR_STS, 1); chk("t3_cnt", ERR_CNT, 1);
        start(8, 2'b00); send(8'h01, 8); smp(1, 1, 0);
        chk("t3_noerr", PAR_ERR, 0); chk("t3_cnt_hold", ERR_CNT, 1);

        // Saturation, then clear colliding with an error.
        clear();
        for (int i = 0; i < 5; i++) begin
            start(8, 2'b00); send(8'h01, 8); smp(1, 0, 0);
        end
        chk("t4_sat", ERR_CNT, 3);
        start(8, 2'b00); send(8'h01, 8); smp(1, 0, 1);
        chk("t4_clr_inc", ERR_CNT, 1); chk("t4_clr_sts", ERR_STS, 1);

        // Abort mid-frame, restart with clamped length in mark mode.
        clear();
        start(8, 2'b00); send(8'h05, 3);
        start(0, 2'b10); send(8'h00, 7);
        chk("t5_not_yet", PAR_VLD, 0);
        send(8'h00, 1);
        chk("t5_vld", PAR_VLD, 1); chk("t5_mark", PAR_BIT, 1);
        chk("t5_flags", {ERR_STS, SEQ_ERR, PAR_ERR}, 0);
        smp(0, 0, 0);

        // Asynchronous reset in the middle of a frame.
        start(8, 2'b01); send(8'hFF, 4);
        #3 RST = 0;
        #1;
        chk("t6_busy", BUSY, 0);
        chk("t6_outs", {PAR_BIT, PAR_VLD, PAR_ERR, ERR_STS, SEQ_ERR, ERR_CNT}, 0);
        @(negedge CLK);
        RST = 1;
        @(negedge CLK);
        start(8, 2'b00); send(8'hB2, 8);
        chk("t6_vld", PAR_VLD, 1); chk("t6_even", PAR_BIT, 0);
        smp(0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            START    = ($urandom_range(0, 39) == 0);
            FRM_LEN  = 4'($urandom_range(0, 15));
            PAR_MODE = 2'($urandom);
            CHK_EN   = ($urandom_range(0, 3) != 0);
            BIT_VLD  = ($urandom_range(0, 2) != 0);
            BIT_IN   = 1'($urandom);
            PAR_SMP  = ($urandom_range(0, 4) == 0);
            CLR_STS  = ($urandom_range(0, 59) == 0);
            @(negedge CLK);
        end
        {START, CHK_EN, BIT_VLD, BIT_IN, PAR_SMP, CLR_STS} = '0;
        @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
